// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count and
// parameter legality checks.
package adder_pkg;

    function automatic int unsigned stages(int unsigned w, int unsigned seg, int unsigned sps);
        return w / (seg * sps);
    endfunction

    function automatic bit width_ok(int unsigned w, int unsigned seg, int unsigned sps);
        return (w > 0) && (seg > 0) && (sps > 0) && ((w % (seg * sps)) == 0);
    endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: both candidate sums are formed up front and the
// incoming carry only drives the final mux.
module csel_segment #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] sum0;
    logic [SEG:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);

    assign {cout, s} = cin ? sum1 : sum0;

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one slice of segments per stage,
// registered inter-stage carry, operand skew and sum de-skew registers.
module csel_adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SEG           = 4,
    parameter int unsigned SEG_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned SliceW = SEG * SEG_PER_STAGE;
    localparam int unsigned Stages = stages(WIDTH, SEG, SEG_PER_STAGE);
    localparam int unsigned SkewN  = (Stages > 1) ? Stages - 1 : 1;

    if (!width_ok(WIDTH, SEG, SEG_PER_STAGE)) begin : g_bad_width
        $error("csel_adder_pipe: WIDTH must be a positive multiple of SEG*SEG_PER_STAGE");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    logic             v_q [Stages];
    logic             v_d [Stages];
    logic             c_q [Stages];
    logic             c_d [Stages];
    logic [WIDTH-1:0] s_q [Stages];
    logic [WIDTH-1:0] s_d [Stages];
    logic [WIDTH-1:0] a_q [SkewN];
    logic [WIDTH-1:0] a_d [SkewN];
    logic [WIDTH-1:0] b_q [SkewN];
    logic [WIDTH-1:0] b_d [SkewN];
    logic             ovf_q;
    logic             ovf_d;

    // The whole pipe freezes only while a result waits at the output.
    assign en       = !v_q[Stages-1] || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub | ci;

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        localparam int unsigned Lo = k * SliceW;
        localparam logic [WIDTH-1:0] Mask = WIDTH'({SliceW{1'b1}}) << Lo;

        logic [WIDTH-1:0]         a_in;
        logic [WIDTH-1:0]         b_in;
        logic [WIDTH-1:0]         s_in;
        logic                     c_in;
        logic                     v_in;
        logic [SEG_PER_STAGE:0]   cy;
        logic [SliceW-1:0]        slice;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c_eff;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
        end

        assign cy[0] = c_in;

        for (genvar j = 0; j < SEG_PER_STAGE; j++) begin : g_seg
            csel_segment #(
                .SEG(SEG)
            ) u_seg (
                .a   (a_in[Lo + j*SEG +: SEG]),
                .b   (b_in[Lo + j*SEG +: SEG]),
                .cin (cy[j]),
                .s   (slice[j*SEG +: SEG]),
                .cout(cy[j+1])
            );
        end

        assign v_d[k] = v_in;
        assign c_d[k] = cy[SEG_PER_STAGE];
        assign s_d[k] = (s_in & ~Mask) | (WIDTH'(slice) << Lo);

        if (k == Stages - 1) begin : g_last
            // Carry into the MSB is recovered as a ^ b ^ s at that bit.
            assign ovf_d = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ slice[SliceW-1] ^ cy[SEG_PER_STAGE];
            if (k > 0) begin : g_unused
                logic unused_lo;
                assign unused_lo = ^{a_in[Lo-1:0], b_in[Lo-1:0]};
            end
        end else begin : g_skew
            assign a_d[k] = a_in;
            assign b_d[k] = b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Stages; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < Stages; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    // Operand skew registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < SkewN; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign out_valid = v_q[Stages-1];
    assign s         = s_q[Stages-1];
    assign co        = c_q[Stages-1];
    assign ovf       = ovf_q;

endmodule
